// File: rtl/my_regfile_if.sv
// rtl/my_regfile_if.sv - write, read, reserve and scoreboard signals of the register bank
interface my_regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        busy_a;
  logic        busy_b;
  logic [31:0] busy_vec;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr,
    input  rdata_a, rdata_b, busy_a, busy_b, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr,
    output rdata_a, rdata_b, busy_a, busy_b, busy_vec
  );
endinterface

// File: rtl/my_regfile.sv
// rtl/my_regfile.sv - 32x32 register bank, two combinational read ports, busy scoreboard
module my_regfile #(
  parameter bit BYPASS = 1'b1
) (
  input logic        clock,
  input logic        reset_n,
  my_regfile_if.slave bus
);
  logic [31:0] regs [1:31];
  logic [31:1] busy;
  logic [31:0] busy_full;
  logic [31:1] sel_a;
  logic [31:1] sel_b;
  logic [31:0] stored_a;
  logic [31:0] stored_b;
  logic        hit_a;
  logic        hit_b;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (bus.we && bus.waddr == 5'(i)) regs[i] <= bus.wdata;
        // A same-cycle reserve wins over the clearing write: it names a newer producer.
        busy[i] <= (busy[i] & ~(bus.we && bus.waddr == 5'(i)))
                   | (bus.rsv_en && bus.rsv_addr == 5'(i));
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    stored_a = '0;
    stored_b = '0;
    for (int i = 1; i < 32; i++) begin
      sel_a[i] = (bus.raddr_a == 5'(i));
      sel_b[i] = (bus.raddr_b == 5'(i));
    end
    // Index 0 has no decoder line, so the AND-OR mux yields zero for it.
    for (int i = 1; i < 32; i++) begin
      stored_a = stored_a | ({32{sel_a[i]}} & regs[i]);
      stored_b = stored_b | ({32{sel_b[i]}} & regs[i]);
    end
  end

  assign hit_a = BYPASS && bus.we && (bus.waddr == bus.raddr_a) && (bus.raddr_a != 5'd0);
  assign hit_b = BYPASS && bus.we && (bus.waddr == bus.raddr_b) && (bus.raddr_b != 5'd0);

  assign bus.rdata_a = hit_a ? bus.wdata : stored_a;
  assign bus.rdata_b = hit_b ? bus.wdata : stored_b;

  assign busy_full    = {busy, 1'b0};
  assign bus.busy_vec = busy_full;
  assign bus.busy_a   = busy_full[bus.raddr_a];
  assign bus.busy_b   = busy_full[bus.raddr_b];
endmodule

// File: tb/tb_my_regfile.sv
// tb/tb_my_regfile.sv - directed vectors for my_regfile with and without write bypass
module tb_my_regfile;
  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  my_regfile_if bus1 ();
  my_regfile_if bus0 ();

  my_regfile #(.BYPASS(1'b1)) dut_bp (.clock(clock), .reset_n(reset_n), .bus(bus1.slave));
  my_regfile #(.BYPASS(1'b0)) dut_nb (.clock(clock), .reset_n(reset_n), .bus(bus0.slave));

  assign bus0.we       = bus1.we;
  assign bus0.waddr    = bus1.waddr;
  assign bus0.wdata    = bus1.wdata;
  assign bus0.raddr_a  = bus1.raddr_a;
  assign bus0.raddr_b  = bus1.raddr_b;
  assign bus0.rsv_en   = bus1.rsv_en;
  assign bus0.rsv_addr = bus1.rsv_addr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] bv;
    logic        ba;
    logic        bb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic rsv_en, input logic [4:0] rsv_addr);
    bus1.we       = we;
    bus1.waddr    = waddr;
    bus1.wdata    = wdata;
    bus1.raddr_a  = ra;
    bus1.raddr_b  = rb;
    bus1.rsv_en   = rsv_en;
    bus1.rsv_addr = rsv_addr;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
      #1;
      chk({tag, "_bp_a"}, bus1.rdata_a, 32'd0);
      chk({tag, "_bp_b"}, bus1.rdata_b, 32'd0);
      chk({tag, "_nb_a"}, bus0.rdata_a, 32'd0);
      chk({tag, "_nb_b"}, bus0.rdata_b, 32'd0);
    end
    chk({tag, "_busy_vec"}, bus1.busy_vec, 32'd0);
    chk({tag, "_busy_a"}, 32'(bus1.busy_a), 32'd0);
    chk({tag, "_busy_b"}, 32'(bus1.busy_b), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            we waddr wdata         ra  rb  rsv addr a1            b1            a0            b0            bv        ba bb
    tbl.push_back('{1, 5,  32'hDEADBEEF, 5,  31, 0,  0,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,    0, 0});
    tbl.push_back('{1, 31, 32'h12345678, 5,  31, 0,  0,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0,        32'h0,    0, 0});
    tbl.push_back('{1, 0,  32'hFFFFFFFF, 0,  5,  0,  0,  32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,    0, 0});
    tbl.push_back('{0, 0,  32'h0,        0,  31, 0,  0,  32'h0,        32'h12345678, 32'h0,        32'h12345678, 32'h0,    0, 0});
    tbl.push_back('{1, 7,  32'hA5A5A5A5, 7,  7,  0,  0,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h0,    0, 0});
    tbl.push_back('{1, 7,  32'h11111111, 7,  5,  0,  0,  32'h11111111, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0,    0, 0});
    tbl.push_back('{0, 0,  32'h0,        9,  7,  1,  9,  32'h0,        32'h11111111, 32'h0,        32'h11111111, 32'h0,    0, 0});
    tbl.push_back('{0, 0,  32'h0,        9,  0,  0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h200,  1, 0});
    tbl.push_back('{1, 9,  32'hCAFEF00D, 9,  9,  0,  0,  32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h0,        32'h200,  1, 1});
    tbl.push_back('{0, 0,  32'h0,        9,  3,  0,  0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0,    0, 0});
    tbl.push_back('{0, 0,  32'h0,        3,  9,  1,  3,  32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,    0, 0});
    tbl.push_back('{1, 3,  32'h33333333, 3,  3,  1,  3,  32'h33333333, 32'h33333333, 32'h0,        32'h0,        32'h8,    1, 1});
    tbl.push_back('{0, 0,  32'h0,        3,  0,  1,  0,  32'h33333333, 32'h0,        32'h33333333, 32'h0,        32'h8,    1, 0});
    tbl.push_back('{0, 0,  32'h0,        0,  3,  0,  0,  32'h0,        32'h33333333, 32'h0,        32'h33333333, 32'h8,    0, 1});
    tbl.push_back('{1, 3,  32'h44444444, 3,  3,  0,  0,  32'h44444444, 32'h44444444, 32'h33333333, 32'h33333333, 32'h8,    1, 1});
    tbl.push_back('{1, 5,  32'h55555555, 5,  3,  0,  0,  32'h55555555, 32'h44444444, 32'hDEADBEEF, 32'h44444444, 32'h0,    0, 0});
    tbl.push_back('{0, 0,  32'h0,        5,  0,  0,  0,  32'h55555555, 32'h0,        32'h55555555, 32'h0,        32'h0,    0, 0});

    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    sweep_zero("reset");

    foreach (tbl[k]) begin
      @(negedge clock);
      drive(tbl[k].we, tbl[k].waddr, tbl[k].wdata, tbl[k].ra, tbl[k].rb,
            tbl[k].rsv_en, tbl[k].rsv_addr);
      #1;
      chk($sformatf("v%0d_bp_a", k), bus1.rdata_a, tbl[k].a1);
      chk($sformatf("v%0d_bp_b", k), bus1.rdata_b, tbl[k].b1);
      chk($sformatf("v%0d_nb_a", k), bus0.rdata_a, tbl[k].a0);
      chk($sformatf("v%0d_nb_b", k), bus0.rdata_b, tbl[k].b0);
      chk($sformatf("v%0d_busy_vec", k), bus1.busy_vec, tbl[k].bv);
      chk($sformatf("v%0d_nb_busy_vec", k), bus0.busy_vec, tbl[k].bv);
      chk($sformatf("v%0d_busy_a", k), 32'(bus1.busy_a), 32'(tbl[k].ba));
      chk($sformatf("v%0d_busy_b", k), 32'(bus1.busy_b), 32'(tbl[k].bb));
    end

    // Reset in the middle of outstanding reservations drops them and a concurrent write.
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd8, 1'b1, 5'd4);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd8, 1'b1, 5'd8);
    @(negedge clock);
    drive(1'b1, 5'd4, 32'h00000055, 5'd4, 5'd8, 1'b1, 5'd12);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd12, 1'b0, 5'd0);
    #1;
    chk("mid_r4", bus1.rdata_a, 32'h00000055);
    chk("mid_busy_vec", bus1.busy_vec, 32'h00001100);
    chk("mid_busy_b", 32'(bus1.busy_b), 32'd1);
    @(negedge clock);
    drive(1'b1, 5'd4, 32'hFFFF0000, 5'd4, 5'd5, 1'b1, 5'd20);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd5, 1'b0, 5'd0);
    #1;
    chk("rst_r4_dropped", bus1.rdata_a, 32'd0);
    chk("rst_r5", bus1.rdata_b, 32'd0);
    chk("rst_busy_vec", bus1.busy_vec, 32'd0);
    sweep_zero("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/my_regfile.md
# my_regfile

Thirty-two-entry, 32-bit register bank with one write port, two combinational read ports and a per-register busy scoreboard. It holds the architectural registers and supplies the CPU's operand-select stage. Each read port uses the 5-to-32 decoder plus 32:1 mux structure. The scoreboard flags registers with an outstanding producer so issue logic can stall on read-after-write hazards.

## Interface
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous reset, active-low
- we  in  1  write enable
- waddr  in  5  write register index
- wdata  in  32  write data
- raddr_a  in  5  read port A index
- raddr_b  in  5  read port B index
- rdata_a  out  32  read port A data, combinational
- rdata_b  out  32  read port B data, combinational
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  5  register index to reserve
- busy_a  out  1  register raddr_a has an outstanding producer
- busy_b  out  1  register raddr_b has an outstanding producer
- busy_vec  out  32  full scoreboard, bit i = register i busy

## Operation
- Storage: regs[1..31], 32 bits each. Register 0 is not stored and always reads 0.
- Write: on clock edge with reset_n=1, we=1 and waddr!=0, regs[waddr] <= wdata. Writes to index 0 are discarded.
- Read: rdata_x = 0 if raddr_x==0.
  - If BYPASS=1, we=1 and waddr==raddr_x!=0: rdata_x = wdata.
  - Otherwise rdata_x = regs[raddr_x].
- Port A and port B are independent. Both may address the same register.
- Scoreboard busy[31:1] is registered; busy[0] is tied to 0.
  - Each edge: busy[i] <= (busy[i] & ~(we & waddr==i)) | (rsv_en & rsv_addr==i).
  - A reserve and a write to the same index in the same cycle leave the register busy: the reserve belongs to a newer producer.
  - rsv_en with rsv_addr==0 is ignored.
  - A write to a non-busy register is legal and leaves it non-busy.
- busy_x = busy[raddr_x]. This is the registered value; the same-cycle write is not considered, even with BYPASS=1.
- busy_vec = busy.

## Timing
- Reset (reset_n low at a rising edge): all regs and all busy bits cleared to 0. The reset edge overrides a concurrent we or rsv_en.
- Resulting outputs: rdata_a/rdata_b = 0 for any address (unless bypassed while reset_n is still low), busy_a=busy_b=0, busy_vec=0.
- Reset asserted mid-sequence discards pending reservations; no write-back is implied.
- Write latency: data is visible through storage on the cycle after the write edge. With BYPASS=1 it is visible combinationally in the write cycle.
- Scoreboard latency: a reserve at edge N gives busy=1 from cycle N+1. A write at edge M clears busy from cycle M+1 (absent a same-cycle reserve).
- No handshakes. Every request completes in one edge and there are no stall outputs on the write or reserve paths.
- Read paths are purely combinational from raddr, regs, we, waddr and wdata. No clock-to-read latency.

## Test plan
- Reset then read: hold reset_n=0 for 2 cycles, release, sweep raddr_a/raddr_b over 0..31 -> every read returns 0, busy_vec=0.
- Write/read: write 0xDEADBEEF to r5, then 0x12345678 to r31 -> next cycle rdata_a(5)=0xDEADBEEF, rdata_b(31)=0x12345678. Write 0xFFFFFFFF to r0 -> reads of r0 return 0.
- Bypass: BYPASS=1, we=1, waddr=7, wdata=0xA5A5A5A5, raddr_a=7 in the same cycle -> rdata_a=0xA5A5A5A5 before the edge. With BYPASS=0 -> old r7 value until the next cycle.
- Scoreboard: reserve r9 -> busy_vec[9]=1 and busy_a=1 (raddr_a=9) the next cycle. Write r9 -> busy clears the following cycle.
- Simultaneous reserve and write: r3 busy, then one cycle with we=1 waddr=3 and rsv_en=1 rsv_addr=3 -> r3 updated, busy[3] stays 1. Reserve r0 -> busy_vec stays 0.
- Reset mid-operation: reserve r4, r8, r12 and write r4=0x55. Assert reset_n=0 for one edge with we=1 -> all regs read 0, busy_vec=0, and the concurrent write is dropped.
